// File: rtl/i2s_rx_frontend_pkg.sv
// i2s_rx_frontend_pkg: receiver state encodings and channel constants.
package i2s_rx_frontend_pkg;
  typedef enum logic [1:0] {RX_HUNT = 2'd0, RX_SHIFT = 2'd1, RX_SKIP = 2'd2} rx_state_t;
  localparam logic CH_LEFT = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_rx_frontend_sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer with a registered copy for rise detection.
module sync_edge_detect #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [stages-1:0] sync_q;
  logic prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[stages-2:0], d};
      prev <= sync_q[stages-1];
    end
  end
  assign level = sync_q[stages-1];
  assign rise = level & ~prev;
endmodule

// File: rtl/i2s_rx_frontend.sv
// i2s_rx_frontend: deserializes one I2S channel into signed samples with overrun/short-slot flags.
module i2s_rx_frontend
  import i2s_rx_frontend_pkg::*;
#(
  parameter int data_width = 16,
  parameter int slot_bits = 32,
  parameter int channel_sel = 0,
  parameter int sync_stages = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_din,
  input  logic                  pipeline_ready,
  input  logic                  overrun_clear,
  output logic [data_width-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  overrun,
  output logic                  short_slot,
  output logic [15:0]           frame_ctr
);
  localparam int bw = $clog2(slot_bits + 1);
  localparam logic [bw-1:0] last_bit = bw'(data_width - 1);
  localparam logic [bw-1:0] bit_max = bw'(slot_bits);
  localparam logic sel = (channel_sel != 0) ? CH_RIGHT : CH_LEFT;
  logic bclk_rise, lr, din, unused_bclk;
  logic [1:0] unused_rise;
  rx_state_t state;
  logic [bw-1:0] bit_idx;
  logic [data_width-1:0] shreg;
  logic lr_prev, commit, boundary;
  sync_edge_detect #(.stages(sync_stages)) u_bclk (.clk(clk), .reset(reset), .d(i2s_bclk), .level(unused_bclk), .rise(bclk_rise));
  sync_edge_detect #(.stages(sync_stages)) u_lrclk (.clk(clk), .reset(reset), .d(i2s_lrclk), .level(lr), .rise(unused_rise[0]));
  sync_edge_detect #(.stages(sync_stages)) u_din (.clk(clk), .reset(reset), .d(i2s_din), .level(din), .rise(unused_rise[1]));
  assign boundary = bclk_rise && (lr != lr_prev);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RX_HUNT;
      bit_idx <= '0;
      shreg <= '0;
      lr_prev <= 1'b0;
      commit <= 1'b0;
      sample_out <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      short_slot <= 1'b0;
      frame_ctr <= '0;
    end else begin
      commit <= 1'b0;
      sample_valid <= commit && pipeline_ready;
      if (commit) frame_ctr <= frame_ctr + 16'd1;
      if (commit && pipeline_ready) sample_out <= shreg;
      overrun <= (commit && !pipeline_ready) || (overrun && !overrun_clear);
      // SHIFT always exits at data_width bits, so a boundary seen in SHIFT is a short slot
      short_slot <= (boundary && state == RX_SHIFT) || (short_slot && !overrun_clear);
      if (boundary) begin
        lr_prev <= lr;
        bit_idx <= '0;
        state <= (lr == sel) ? RX_SHIFT : RX_SKIP;
      end else if (bclk_rise && state == RX_SHIFT) begin
        shreg <= {shreg[data_width-2:0], din};
        bit_idx <= bit_idx + 1'b1;
        if (bit_idx == last_bit) begin
          commit <= 1'b1;
          state <= RX_SKIP;
        end
      end else if (bclk_rise && state == RX_SKIP && bit_idx != bit_max) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_rx_frontend.sv
// tb_i2s_rx_frontend: slot-level I2S model checked against left and right receivers every cycle.
module tb_i2s_rx_frontend;
  logic clk = 1'b0, reset = 1'b1, bclk = 1'b0, lrclk = 1'b0, din = 1'b0, ready = 1'b1, clr = 1'b0;
  logic [15:0] out0, out1, ctr0, ctr1;
  logic v0, v1, ov0, ov1, sh0, sh1;
  always #5 clk = ~clk;
  i2s_rx_frontend #(.channel_sel(0)) dut0 (
    .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_din(din),
    .pipeline_ready(ready), .overrun_clear(clr), .sample_out(out0), .sample_valid(v0),
    .overrun(ov0), .short_slot(sh0), .frame_ctr(ctr0));
  i2s_rx_frontend #(.channel_sel(1)) dut1 (
    .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_din(din),
    .pipeline_ready(ready), .overrun_clear(clr), .sample_out(out1), .sample_valid(v1),
    .overrun(ov1), .short_slot(sh1), .frame_ctr(ctr1));
  localparam int K_SAMPLE = 0, K_SHORT = 1, K_RESET = 2;
  typedef struct {int cyc; int ch; int kind; logic [15:0] val;} ev_t;
  ev_t evq[$];
  int cyc = 0, vectors = 0, miscompares = 0, clr_cyc = -1, pcnt0 = 0;
  logic m_lr = 1'b0;
  logic m_active[2] = '{1'b0, 1'b0};
  int m_bits[2] = '{0, 0};
  logic [15:0] m_word[2] = '{16'h0, 16'h0};
  logic [15:0] m_out[2] = '{16'h0, 16'h0};
  logic [15:0] m_ctr[2] = '{16'h0, 16'h0};
  logic m_valid[2] = '{1'b0, 1'b0};
  logic m_ovr[2] = '{1'b0, 1'b0};
  logic m_short[2] = '{1'b0, 1'b0};
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
    end
  endtask
  task automatic apply_ev(input ev_t e);
    if (e.kind == K_SAMPLE) begin
      m_ctr[e.ch] = m_ctr[e.ch] + 16'd1;
      if (ready) begin
        m_out[e.ch] = e.val;
        m_valid[e.ch] = 1'b1;
      end else m_ovr[e.ch] = 1'b1;
    end else if (e.kind == K_SHORT) m_short[e.ch] = 1'b1;
    else begin
      m_out[e.ch] = 16'h0;
      m_ctr[e.ch] = 16'h0;
      m_ovr[e.ch] = 1'b0;
      m_short[e.ch] = 1'b0;
    end
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    m_valid = '{1'b0, 1'b0};
    if (cyc == clr_cyc) begin
      m_ovr = '{1'b0, 1'b0};
      m_short = '{1'b0, 1'b0};
    end
    for (int i = evq.size() - 1; i >= 0; i--)
      if (evq[i].cyc == cyc) begin
        apply_ev(evq[i]);
        evq.delete(i);
      end
    if (v0 === 1'b1) pcnt0++;
    chk("out0", out0, m_out[0]);
    chk("valid0", 16'(v0), 16'(m_valid[0]));
    chk("overrun0", 16'(ov0), 16'(m_ovr[0]));
    chk("short0", 16'(sh0), 16'(m_short[0]));
    chk("ctr0", ctr0, m_ctr[0]);
    chk("out1", out1, m_out[1]);
    chk("valid1", 16'(v1), 16'(m_valid[1]));
    chk("overrun1", 16'(ov1), 16'(m_ovr[1]));
    chk("short1", 16'(sh1), 16'(m_short[1]));
    chk("ctr1", ctr1, m_ctr[1]);
  end
  // Slot-level view: a selected slot yields a word from its 16 bits after the boundary bit
  task automatic model_edge(input logic lr, input logic d, input int p);
    if (lr != m_lr) begin
      for (int c = 0; c < 2; c++) begin
        if (m_active[c] && m_bits[c] < 16) evq.push_back('{p + 3, c, K_SHORT, 16'h0});
        m_active[c] = (int'(lr) == c);
        m_bits[c] = 0;
      end
      m_lr = lr;
    end else
      for (int c = 0; c < 2; c++)
        if (m_active[c]) begin
          m_word[c] = {m_word[c][14:0], d};
          m_bits[c]++;
          if (m_bits[c] == 16) begin
            evq.push_back('{p + 4, c, K_SAMPLE, m_word[c]});
            m_active[c] = 1'b0;
          end
        end
  endtask
  task automatic edge_bit(input logic lr, input logic d);
    @(negedge clk);
    bclk = 1'b0;
    lrclk = lr;
    din = d;
    repeat (3) @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    model_edge(lr, d, cyc);
    repeat (3) @(negedge clk);
  endtask
  task automatic send_slot(input logic lr, input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) edge_bit(lr, (i >= 1 && i <= 16) ? w[16-i] : 1'b1);
  endtask
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    bclk = 1'b0;
    evq.push_back('{cyc + 1, 0, K_RESET, 16'h0});
    evq.push_back('{cyc + 1, 1, K_RESET, 16'h0});
    m_lr = 1'b0;
    m_active = '{1'b0, 1'b0};
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    clr_cyc = cyc + 1;
    @(negedge clk);
    clr = 1'b0;
  endtask
  initial begin
    do_reset(4);
    chk("rst_out", out0, 16'h0);
    chk("rst_valid", 16'(v0), 16'h0);
    chk("rst_ovr", 16'(ov0), 16'h0);
    chk("rst_short", 16'(sh0), 16'h0);
    chk("rst_ctr", ctr0, 16'h0);
    send_slot(1'b0, 16'hFFFF, 20);
    send_slot(1'b1, 16'h0000, 20);
    chk("hunt_ctr0", ctr0, 16'h0);
    chk("hunt_ctr1", ctr1, 16'h1);
    send_slot(1'b0, 16'h1234, 20);
    chk("nom_out", out0, 16'h1234);
    chk("nom_ctr", ctr0, 16'h1);
    chk("nom_pulses", 16'(pcnt0), 16'h1);
    send_slot(1'b1, 16'hBEEF, 20);
    chk("right_hold0", out0, 16'h1234);
    chk("right_out1", out1, 16'hBEEF);
    send_slot(1'b0, 16'h1111, 20);
    send_slot(1'b1, 16'h0000, 20);
    ready = 1'b0;
    send_slot(1'b0, 16'h5555, 20);
    ready = 1'b1;
    chk("ovr_flag", 16'(ov0), 16'h1);
    chk("ovr_hold", out0, 16'h1111);
    chk("ovr_ctr", ctr0, 16'h3);
    send_slot(1'b1, 16'h0000, 20);
    pulse_clear();
    chk("ovr_clear", 16'(ov0), 16'h0);
    send_slot(1'b0, 16'h8000, 20);
    chk("neg_fs", out0, 16'h8000);
    send_slot(1'b1, 16'h0000, 20);
    send_slot(1'b0, 16'h7FFF, 20);
    chk("pos_fs", out0, 16'h7FFF);
    send_slot(1'b1, 16'h0000, 20);
    send_slot(1'b0, 16'hFFFF, 9);
    send_slot(1'b1, 16'h0000, 20);
    chk("short_flag", 16'(sh0), 16'h1);
    chk("short_ctr", ctr0, 16'h5);
    send_slot(1'b0, 16'h00A5, 20);
    chk("after_short", out0, 16'h00A5);
    chk("after_short_ctr", ctr0, 16'h6);
    pulse_clear();
    chk("short_clear", 16'(sh0), 16'h0);
    send_slot(1'b1, 16'h0000, 20);
    send_slot(1'b0, 16'hABCD, 8);
    do_reset(3);
    chk("midrst_out0", out0, 16'h0);
    chk("midrst_ctr0", ctr0, 16'h0);
    chk("midrst_out1", out1, 16'h0);
    send_slot(1'b0, 16'hABCD, 12);
    send_slot(1'b1, 16'h0000, 20);
    send_slot(1'b0, 16'h2468, 20);
    chk("post_rst_out", out0, 16'h2468);
    chk("post_rst_ctr", ctr0, 16'h1);
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
